// File: rtl/sd_conversion_scheduler.sv
// Round-robin scheduler sharing one signed-digit online-to-binary converter.
// Streams the granted source's digits and returns the converted value tagged with the source id.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   req_valid/req_digit   per-source digit streams (2 bits each, MSD first)
//   req_ready             one-hot; the granted source's digit is consumed
//   conv_a/conv_start     digit and first-digit strobe to the converter
//   conv_o                converter parallel result (combinational from conv_a)
//   res_valid/res_ready   result handshake, with res_data/res_id held
//   busy                  scheduler not idle
//   abort                 one-cycle pulse after the granted source stalls mid-stream
module sd_conversion_scheduler #(
    parameter int NREQ   = 4,
    parameter int DIGITS = 12,
    parameter int WIDTH  = 14,
    parameter int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [2*NREQ-1:0] req_digit,
    output logic [NREQ-1:0]   req_ready,
    output logic [1:0]        conv_a,
    output logic              conv_start,
    input  logic [WIDTH-1:0]  conv_o,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_data,
    output logic [IDW-1:0]    res_id,
    output logic              busy,
    output logic              abort
);

    localparam int DCW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DCW-1:0] LAST = DCW'(DIGITS - 1);
    localparam logic [IDW-1:0] MAX_ID = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   grant_d;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   rr_ptr_d;
    logic [DCW-1:0]   dcnt;
    logic [DCW-1:0]   dcnt_d;
    logic [WIDTH-1:0] res_data_d;
    logic [IDW-1:0]   res_id_d;
    logic             abort_d;

    logic             pick_found;
    logic [IDW-1:0]   pick_id;
    logic [IDW-1:0]   pick_next;
    logic             cur_valid;
    logic [1:0]       cur_digit;

    // The granted source is the only one whose digits are looked at.
    assign cur_valid = req_valid[grant];
    assign cur_digit = req_digit[{grant, 1'b0} +: 2];

    // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!pick_found && req_valid[IDW'(idx)]) begin
                pick_found = 1'b1;
                pick_id    = IDW'(idx);
            end
        end
    end

    // Pointer moves just past the winner so it has lowest priority next time.
    assign pick_next = (pick_id == MAX_ID) ? '0 : pick_id + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            dcnt     <= '0;
            res_data <= '0;
            res_id   <= '0;
            abort    <= 1'b0;
        end else begin
            state    <= state_d;
            grant    <= grant_d;
            rr_ptr   <= rr_ptr_d;
            dcnt     <= dcnt_d;
            res_data <= res_data_d;
            res_id   <= res_id_d;
            abort    <= abort_d;
        end
    end

    always_comb begin
        state_d    = state;
        grant_d    = grant;
        rr_ptr_d   = rr_ptr;
        dcnt_d     = dcnt;
        res_data_d = res_data;
        res_id_d   = res_id;
        abort_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_d  = pick_id;
                    rr_ptr_d = pick_next;
                    dcnt_d   = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (!cur_valid) begin
                    // Partial conversion is dropped; the next
                    // conv_start clears the converter.
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (dcnt == LAST) begin
                    // conv_o already includes the last digit.
                    res_data_d = conv_o;
                    res_id_d   = grant;
                    state_d    = HOLD;
                end else begin
                    dcnt_d = dcnt + 1'b1;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready  = '0;
        conv_a     = 2'b00;
        conv_start = 1'b0;
        if (state == STREAM) begin
            req_ready[grant] = 1'b1;
            conv_a           = cur_digit;
            conv_start       = (dcnt == '0);
        end
    end

    assign res_valid = (state == HOLD);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sd_conversion_scheduler.sv
// Directed bench for sd_conversion_scheduler.
// Models the digit sources and a behavioural online-to-binary converter.
module tb_sd_conversion_scheduler;

    localparam int NREQ   = 4;
    localparam int DIGITS = 12;
    localparam int WIDTH  = 14;
    localparam int IDW    = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_digit;
    logic [NREQ-1:0]   req_ready;
    logic [1:0]        conv_a;
    logic              conv_start;
    logic [WIDTH-1:0]  conv_o;
    logic              res_valid;
    logic              res_ready;
    logic [WIDTH-1:0]  res_data;
    logic [IDW-1:0]    res_id;
    logic              busy;
    logic              abort;

    int passed = 0;
    int total  = 0;

    logic [1:0]       seq [NREQ][DIGITS];
    int               idx [NREQ];
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] dv;

    sd_conversion_scheduler #(
        .NREQ(NREQ), .DIGITS(DIGITS), .WIDTH(WIDTH), .IDW(IDW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_digit(req_digit),
        .req_ready(req_ready),
        .conv_a(conv_a),
        .conv_start(conv_start),
        .conv_o(conv_o),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_id(res_id),
        .busy(busy),
        .abort(abort)
    );

    always #5 clk = ~clk;

    // Each source presents seq[i][idx[i]] and advances when consumed.
    always_comb begin
        req_digit = '0;
        for (int i = 0; i < NREQ; i++)
            req_digit[2*i +: 2] = seq[i][idx[i]];
    end

    // Converter: value = 2*previous + digit, restarted by conv_start.
    always_comb begin
        case (conv_a)
            2'b10:   dv = 14'd1;
            2'b01:   dv = 14'h3FFF;
            default: dv = 14'd0;
        endcase
        conv_o = (conv_start ? 14'd0 : (acc << 1)) + dv;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) idx[i] <= 0;
            acc <= '0;
        end else begin
            if (abort) begin
                for (int i = 0; i < NREQ; i++) idx[i] <= 0;
            end else begin
                for (int i = 0; i < NREQ; i++)
                    if (req_ready[i] && req_valid[i])
                        idx[i] <= (idx[i] == DIGITS-1) ? 0 : idx[i] + 1;
            end
            if (|(req_ready & req_valid)) acc <= conv_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh2id(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b0; req_valid = 4'hF; res_ready = 1'b1;
        tick();
        tick();
        total++; if (req_ready !== 4'h0) $display("FAIL rst_req_ready got %h want 0", req_ready); else passed++;
        total++; if (conv_a !== 2'b00) $display("FAIL rst_conv_a got %b want 00", conv_a); else passed++;
        total++; if (conv_start !== 1'b0) $display("FAIL rst_conv_start got %b want 0", conv_start); else passed++;
        total++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid got %b want 0", res_valid); else passed++;
        total++; if (res_data !== 14'h0) $display("FAIL rst_res_data got %h want 0", res_data); else passed++;
        total++; if (res_id !== 2'd0) $display("FAIL rst_res_id got %0d want 0", res_id); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
        total++; if (abort !== 1'b0) $display("FAIL rst_abort got %b want 0", abort); else passed++;
        req_valid = 4'h0; res_ready = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int rdy_n, st_n, st_k, early;
        for (int j = 0; j < DIGITS; j++) seq[1][j] = 2'b10;
        req_valid = 4'b0010; res_ready = 1'b0;
        tick();
        rdy_n = 0; st_n = 0; st_k = -1; early = 0;
        for (int k = 0; k < DIGITS; k++) begin
            if (req_ready === 4'b0010) rdy_n++;
            if (conv_start === 1'b1) begin st_n++; st_k = k; end
            if (res_valid !== 1'b0) early++;
            tick();
        end
        total++; if (rdy_n != 12) $display("FAIL single_ready_cycles got %0d want 12", rdy_n); else passed++;
        total++; if (st_n != 1 || st_k != 0) $display("FAIL single_conv_start got %0d@%0d want 1@0", st_n, st_k); else passed++;
        total++; if (early != 0) $display("FAIL single_early_valid got %0d want 0", early); else passed++;
        total++; if (res_valid !== 1'b1) $display("FAIL single_res_valid got %b want 1", res_valid); else passed++;
        total++; if (res_data !== 14'h0FFF) $display("FAIL single_res_data got %h want 0fff", res_data); else passed++;
        total++; if (res_id !== 2'd1) $display("FAIL single_res_id got %0d want 1", res_id); else passed++;
        total++; if (req_ready !== 4'h0) $display("FAIL single_hold_ready got %h want 0", req_ready); else passed++;
        req_valid = 4'h0; res_ready = 1'b1;
        tick();
        total++; if (res_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_release got v=%b b=%b want 0 0", res_valid, busy); else passed++;
        res_ready = 1'b0;
    endtask

    task automatic test_neg_msd();
        logic [1:0] zc [2];
        zc[0] = 2'b00; zc[1] = 2'b11;
        for (int r = 0; r < 2; r++) begin
            seq[0][0] = 2'b01;
            for (int j = 1; j < DIGITS; j++) seq[0][j] = zc[r];
            req_valid = 4'b0001; res_ready = 1'b0;
            tick();
            repeat (DIGITS) tick();
            total++; if (res_valid !== 1'b1) $display("FAIL neg_res_valid z=%b got %b want 1", zc[r], res_valid); else passed++;
            total++; if (res_data !== 14'h3800) $display("FAIL neg_res_data z=%b got %h want 3800", zc[r], res_data); else passed++;
            total++; if (res_id !== 2'd0) $display("FAIL neg_res_id z=%b got %0d want 0", zc[r], res_id); else passed++;
            req_valid = 4'h0; res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int gid [5];
        int gcy [5];
        int rid [5];
        logic [WIDTH-1:0] rdat [5];
        logic [WIDTH-1:0] exp_d [4];
        int exp_o [5];
        int ng, nres, cyc;
        exp_d[0] = 14'h0FFF; exp_d[1] = 14'h3001;
        exp_d[2] = 14'h0555; exp_d[3] = 14'h0800;
        exp_o[0] = 0; exp_o[1] = 1; exp_o[2] = 2; exp_o[3] = 3; exp_o[4] = 0;
        reset = 1'b0; req_valid = 4'h0; res_ready = 1'b0;
        tick();
        reset = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            seq[0][j] = 2'b10;
            seq[1][j] = 2'b01;
            seq[2][j] = (j % 2 == 0) ? 2'b10 : 2'b01;
            seq[3][j] = (j == 0) ? 2'b10 : 2'b00;
        end
        for (int i = 0; i < 5; i++) begin gid[i] = -1; gcy[i] = 0; rid[i] = -1; rdat[i] = '0; end
        ng = 0; nres = 0; cyc = 0;
        req_valid = 4'hF; res_ready = 1'b1;
        for (int c = 0; c < 120 && nres < 5; c++) begin
            tick();
            cyc++;
            if (conv_start === 1'b1) begin
                if (ng < 5) begin gid[ng] = oh2id(req_ready); gcy[ng] = cyc; end
                ng++;
            end
            if (res_valid === 1'b1) begin
                if (nres < 5) begin rid[nres] = int'(res_id); rdat[nres] = res_data; end
                nres++;
                if (nres == 5) req_valid = 4'h0;
            end
        end
        total++; if (nres != 5 || ng != 5) $display("FAIL rr_counts got g=%0d r=%0d want 5 5", ng, nres); else passed++;
        for (int i = 0; i < 5; i++) begin
            total++; if (gid[i] != exp_o[i]) $display("FAIL rr_grant%0d got %0d want %0d", i, gid[i], exp_o[i]); else passed++;
            total++; if (rid[i] != exp_o[i] || rdat[i] !== exp_d[exp_o[i]])
                $display("FAIL rr_result%0d got id=%0d d=%h want id=%0d d=%h", i, rid[i], rdat[i], exp_o[i], exp_d[exp_o[i]]);
            else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            total++; if (gcy[i+1] - gcy[i] != 14) $display("FAIL rr_spacing%0d got %0d want 14", i, gcy[i+1] - gcy[i]); else passed++;
        end
        tick();
        tick();
        total++; if (busy !== 1'b0) $display("FAIL rr_idle_after got %b want 0", busy); else passed++;
        res_ready = 1'b0;
    endtask

    task automatic test_abort();
        int ab_n;
        for (int j = 0; j < DIGITS; j++) seq[2][j] = 2'b10;
        req_valid = 4'b0100; res_ready = 1'b0;
        tick();
        ab_n = 0;
        for (int k = 0; k < 5; k++) begin
            if (abort === 1'b1) ab_n++;
            tick();
        end
        total++; if (req_ready !== 4'b0100) $display("FAIL abort_pre_ready got %h want 4", req_ready); else passed++;
        req_valid = 4'b1001;
        tick();
        if (abort === 1'b1) ab_n++;
        total++; if (abort !== 1'b1) $display("FAIL abort_pulse got %b want 1", abort); else passed++;
        total++; if (res_valid !== 1'b0 || busy !== 1'b0) $display("FAIL abort_state got v=%b b=%b want 0 0", res_valid, busy); else passed++;
        tick();
        if (abort === 1'b1) ab_n++;
        total++; if (abort !== 1'b0) $display("FAIL abort_width got %b want 0", abort); else passed++;
        total++; if (req_ready !== 4'b1000 || conv_start !== 1'b1) $display("FAIL abort_next_grant got %h s=%b want 8 1", req_ready, conv_start); else passed++;
        req_valid = 4'b1000;
        for (int c = 0; c < 30 && res_valid !== 1'b1; c++) begin
            tick();
            if (abort === 1'b1) ab_n++;
        end
        total++; if (res_valid !== 1'b1 || res_id !== 2'd3 || res_data !== 14'h0800)
            $display("FAIL abort_followup got v=%b id=%0d d=%h want 1 3 0800", res_valid, res_id, res_data);
        else passed++;
        total++; if (ab_n != 1) $display("FAIL abort_count got %0d want 1", ab_n); else passed++;
        req_valid = 4'h0; res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_hold_stall();
        int d_bad, i_bad, r_bad, b_bad;
        for (int j = 0; j < DIGITS; j++) seq[1][j] = 2'b10;
        req_valid = 4'b0010; res_ready = 1'b0;
        tick();
        for (int c = 0; c < 30 && res_valid !== 1'b1; c++) tick();
        total++; if (res_valid !== 1'b1) $display("FAIL stall_reach_hold got %b want 1", res_valid); else passed++;
        req_valid = 4'hF;
        d_bad = 0; i_bad = 0; r_bad = 0; b_bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (res_data !== 14'h0FFF) d_bad++;
            if (res_id !== 2'd1) i_bad++;
            if (req_ready !== 4'h0) r_bad++;
            if (busy !== 1'b1 || res_valid !== 1'b1) b_bad++;
        end
        total++; if (d_bad != 0) $display("FAIL stall_data got %0d bad cycles want 0", d_bad); else passed++;
        total++; if (i_bad != 0) $display("FAIL stall_id got %0d bad cycles want 0", i_bad); else passed++;
        total++; if (r_bad != 0) $display("FAIL stall_ready got %0d bad cycles want 0", r_bad); else passed++;
        total++; if (b_bad != 0) $display("FAIL stall_busy got %0d bad cycles want 0", b_bad); else passed++;
        res_ready = 1'b1;
        tick();
        total++; if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 4'h0)
            $display("FAIL stall_release got b=%b v=%b r=%h want 0 0 0", busy, res_valid, req_ready);
        else passed++;
        req_valid = 4'h0; res_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < DIGITS; j++) seq[0][j] = 2'b10;
        req_valid = 4'b0001; res_ready = 1'b0;
        tick();
        repeat (7) tick();
        total++; if (busy !== 1'b1 || req_ready !== 4'b0001) $display("FAIL rstm_pre got b=%b r=%h want 1 1", busy, req_ready); else passed++;
        #2 reset = 1'b0;
        #1;
        total++; if (req_ready !== 4'h0 || conv_start !== 1'b0 || busy !== 1'b0 || abort !== 1'b0 || conv_a !== 2'b00)
            $display("FAIL rstm_stream got r=%h s=%b b=%b a=%b c=%b want 0", req_ready, conv_start, busy, abort, conv_a);
        else passed++;
        tick();
        reset = 1'b1;
        req_valid = 4'hF;
        tick();
        total++; if (req_ready !== 4'b0001 || abort !== 1'b0) $display("FAIL rstm_priority1 got r=%h a=%b want 1 0", req_ready, abort); else passed++;
        for (int c = 0; c < 30 && res_valid !== 1'b1; c++) tick();
        total++; if (res_valid !== 1'b1 || res_data !== 14'h0FFF) $display("FAIL rstm_hold got v=%b d=%h want 1 0fff", res_valid, res_data); else passed++;
        #2 reset = 1'b0;
        #1;
        total++; if (res_valid !== 1'b0 || res_data !== 14'h0 || res_id !== 2'd0 || busy !== 1'b0 || abort !== 1'b0)
            $display("FAIL rstm_holdrst got v=%b d=%h id=%0d b=%b a=%b want 0", res_valid, res_data, res_id, busy, abort);
        else passed++;
        tick();
        reset = 1'b1;
        tick();
        total++; if (req_ready !== 4'b0001 || abort !== 1'b0) $display("FAIL rstm_priority2 got r=%h a=%b want 1 0", req_ready, abort); else passed++;
        reset = 1'b0; req_valid = 4'h0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < DIGITS; j++) seq[i][j] = 2'b00;
        test_reset();
        test_single();
        test_neg_msd();
        test_back_to_back();
        test_abort();
        test_hold_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
